// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - pending-write queue feeding the register file write port
//
// Accepts up to two write-back results per cycle (slot 0 older than slot 1),
// keeps them in program order in a circular queue and retires one per cycle
// onto the register file's single write port. A forwarding lookup exposes the
// youngest pending or incoming value for a given register.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   - writes to register 0 are dropped, lookups of register 0 miss
//   undefined - register 0 behaves like every other register
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in0_valid/in0_rd/in0_data      older incoming write
//   in1_valid/in1_rd/in1_data      younger incoming write
//   in_ready                       queue has room for two entries
//   wr_en/wr_addr/wr_data          register file WE3/A3/WD3
//   fwd_addr/fwd_hit/fwd_data      forwarding lookup
//   idle                           queue empty and nothing incoming

module regfile_write_port #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [AW-1:0] in0_rd,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  input  logic [AW-1:0] in1_rd,
  input  logic [DW-1:0] in1_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_rd   [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          acc0;
  logic          acc1;
  logic          deq;
  logic [PW-1:0] slot1;
  logic [CW-1:0] n_enq;
  logic [PW-1:0] idx;

  // Room for two is required even when only one slot is valid, so the
  // producer sees a single, registered ready condition.
  assign in_ready = (count <= CW'(DEPTH - 2));

`ifdef REGFILE_ZERO_REG_EN
  assign acc0 = in_ready && in0_valid && (in0_rd != '0);
  assign acc1 = in_ready && in1_valid && (in1_rd != '0);
`else
  assign acc0 = in_ready && in0_valid;
  assign acc1 = in_ready && in1_valid;
`endif

  assign deq   = (count != '0);
  // A lone slot-1 write lands at the tail so the queue never has holes.
  assign slot1 = tail + PW'(acc0);
  assign n_enq = CW'(acc0) + CW'(acc1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (acc0) begin
        q_rd[tail]   <= in0_rd;
        q_data[tail] <= in0_data;
      end
      if (acc1) begin
        q_rd[slot1]   <= in1_rd;
        q_data[slot1] <= in1_data;
      end
      tail  <= tail + PW'(n_enq);
      head  <= head + PW'(deq);
      count <= count + n_enq - CW'(deq);
    end
  end

  // Write port comes straight from flops: stable for the whole cycle.
  assign wr_en   = deq;
  assign wr_addr = q_rd[head];
  assign wr_data = q_data[head];

  assign idle = (count == '0) && !in0_valid && !in1_valid;

  // Scan oldest to youngest so later matches override earlier ones; the
  // incoming slots are younger than anything queued and are applied last.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (q_rd[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[idx];
      end
    end
    if (acc0 && (in0_rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = in0_data;
    end
    if (acc1 && (in1_rd == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = in1_data;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (fwd_addr == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - directed self-checking bench for regfile_write_port

module tb_regfile_write_port;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in0_valid = 1'b0;
  logic [AW-1:0] in0_rd = '0;
  logic [DW-1:0] in0_data = '0;
  logic          in1_valid = 1'b0;
  logic [AW-1:0] in1_rd = '0;
  logic [DW-1:0] in1_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          idle;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] rf [8];
  logic [31:0]   wlog [$];
  logic [31:0]   exp_log [$];

  regfile_write_port #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_rd    (in0_rd),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_rd    (in1_rd),
    .in1_data  (in1_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Register file model: captures on the negedge inside the write cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      rf[wr_addr] <= wr_data;
      wlog.push_back({13'b0, wr_addr, wr_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
  endtask

  function automatic logic [31:0] ent(input logic [AW-1:0] r, input logic [DW-1:0] d);
    return {13'b0, r, d};
  endfunction

  task automatic compare_log(input string tag);
    check({tag, "_count"}, wlog.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      check(tag, (i < wlog.size()) ? wlog[i] : 32'hdead_beef, exp_log[i]);
    end
    wlog.delete();
    exp_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ready [6];
    logic rdy;
    int   p;
    exp_ready = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_wr_en",    wr_en,    0);
    check("rst_wr_addr",  wr_addr,  0);
    check("rst_wr_data",  wr_data,  0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fwd_hit",  fwd_hit,  0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_idle",     idle,     1);
    step();
    step();
    rst = 1'b0;
    step();
    wlog.delete();

    // Single write
    fwd_addr = 3'd5;
    drive(1, 3'd5, 16'h1234, 0, 3'd0, 16'h0);
    #1;
    check("single_fwd_incoming", {fwd_hit, fwd_data}, {1'b1, 16'h1234});
    step();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("single_wr_en",   wr_en,   1);
    check("single_wr_addr", wr_addr, 5);
    check("single_wr_data", wr_data, 16'h1234);
    check("single_fwd_queued", {fwd_hit, fwd_data}, {1'b1, 16'h1234});
    step();
    check("single_rf5",     rf[5],   16'h1234);
    check("single_wr_en_after", wr_en, 0);
    check("single_idle",    idle,    1);
    exp_log.push_back(ent(3'd5, 16'h1234));
    compare_log("single_log");

    // Same-register ordering
    fwd_addr = 3'd2;
    drive(1, 3'd2, 16'hAAAA, 1, 3'd2, 16'hBBBB);
    #1;
    check("order_fwd_incoming", {fwd_hit, fwd_data}, {1'b1, 16'hBBBB});
    step();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("order_first",  wr_data, 16'hAAAA);
    check("order_fwd_q2", {fwd_hit, fwd_data}, {1'b1, 16'hBBBB});
    step();
    check("order_second", wr_data, 16'hBBBB);
    check("order_fwd_q1", {fwd_hit, fwd_data}, {1'b1, 16'hBBBB});
    step();
    check("order_wr_en_off", wr_en, 0);
    check("order_rf2",    rf[2],   16'hBBBB);
    check("order_fwd_empty", {fwd_hit, fwd_data}, {1'b0, 16'h0});
    exp_log.push_back(ent(3'd2, 16'hAAAA));
    exp_log.push_back(ent(3'd2, 16'hBBBB));
    compare_log("order_log");

    // Fill and backpressure: four pairs offered back to back
    for (int k = 0; k < 8; k++) exp_log.push_back(ent(AW'((k % 7) + 1), DW'(16'h1000 + k)));
    p = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, AW'(((2 * p) % 7) + 1), DW'(16'h1000 + 2 * p),
            1, AW'(((2 * p + 1) % 7) + 1), DW'(16'h1000 + 2 * p + 1));
      #1;
      check("fill_ready", in_ready, exp_ready[c]);
      rdy = in_ready;
      step();
      if (rdy) p++;
    end
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("fill_pairs_accepted", p, 4);
    for (int w = 0; w < 20 && !idle; w++) step();
    check("fill_drained", idle, 1);
    compare_log("fill_log");

    // Wrap-around: single writes alternating slot 0 / slot 1, with gaps
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) drive(1, AW'((k % 7) + 1), DW'(16'h5000 + k), 0, 3'd0, 16'h0);
      else            drive(0, 3'd0, 16'h0, 1, AW'((k % 7) + 1), DW'(16'h5000 + k));
      step();
      drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("wrap_wr_data", {wr_en, wr_data}, {1'b1, DW'(16'h5000 + k)});
      exp_log.push_back(ent(AW'((k % 7) + 1), DW'(16'h5000 + k)));
      step();
    end
    check("wrap_idle", idle, 1);
    compare_log("wrap_log");

    // Reset during a burst with three entries queued
    drive(1, 3'd3, 16'h7001, 1, 3'd4, 16'h7002);
    step();
    drive(1, 3'd5, 16'h7003, 1, 3'd6, 16'h7004);
    step();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("burst_ready_full", in_ready, 0);
    rst = 1'b1;
    #1;
    check("burst_rst_wr_en", wr_en, 0);
    step();
    rst = 1'b0;
    step();
    check("burst_idle",     idle,     1);
    check("burst_in_ready", in_ready, 1);
    check("burst_wr_en",    wr_en,    0);
    wlog.delete();

    // Register zero
    fwd_addr = 3'd0;
    drive(1, 3'd0, 16'hFFFF, 0, 3'd0, 16'h0);
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("zero_fwd", {fwd_hit, fwd_data}, {1'b0, 16'h0});
    step();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("zero_wr_en", wr_en, 0);
    step();
    check("zero_no_write", wlog.size(), 0);
`else
    check("zero_fwd", {fwd_hit, fwd_data}, {1'b1, 16'hFFFF});
    step();
    drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
    check("zero_wr", {wr_en, wr_addr}, {1'b1, 3'd0});
    step();
    check("zero_rf0", rf[0], 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
